mix_columns_unit: RTL and testbench



---
 rtl/mix_columns_unit.sv | 137 +++++++++++++
 tb/tb_mix_columns_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_unit.sv
// Sequential AES MixColumns engine: COLS_PER_CYCLE columns per cycle, valid/ready on both sides.
// Define MIXCOL_INV_EN to build the InvMixColumns network, selected per transaction by in_inv.
module mix_columns_unit #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Groups are aligned to COLS_PER_CYCLE, so the same mask gives the last group start
  // and the counter bits that identify a group.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] GRP_MASK = 2'(4 - COLS_PER_CYCLE);

  state_t       state_reg, state_next;
  logic [127:0] data_reg, data_next, data_proc;
  logic [1:0]   cnt_reg, cnt_next;
  logic [COLS_PER_CYCLE-1:0][31:0] lane_out;

`ifdef MIXCOL_INV_EN
  logic inv_reg, inv_next;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // k is a 4-bit coefficient decomposed onto the xtime chain b, 2b, 4b, 8b.
  function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [3:0] k0,
                                          input logic [3:0] k1, input logic [3:0] k2,
                                          input logic [3:0] k3);
    logic [7:0]  a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    r = '0;
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = mul(a[i], k0) ^ mul(a[(i+1)%4], k1) ^
                       mul(a[(i+2)%4], k2) ^ mul(a[(i+3)%4], k3);
    return r;
  endfunction

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
    logic [1:0]  idx;
    logic [31:0] col_in, col_fwd;
    assign idx     = cnt_reg + 2'(gi);
    assign col_in  = data_reg[{~idx, 5'b0} +: 32];
    assign col_fwd = mix_col(col_in, 4'h2, 4'h3, 4'h1, 4'h1);
`ifdef MIXCOL_INV_EN
    assign lane_out[gi] = inv_reg ? mix_col(col_in, 4'he, 4'hb, 4'hd, 4'h9) : col_fwd;
`else
    assign lane_out[gi] = col_fwd;
`endif
  end

  // Column gi is owned by lane gi % COLS_PER_CYCLE whenever its group is the current one.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    localparam int LANE = gi % COLS_PER_CYCLE;
    logic active;
    assign active = ((2'(gi) ^ cnt_reg) & GRP_MASK) == 2'b00;
    assign data_proc[(3-gi)*32 +: 32] = active ? lane_out[LANE] : data_reg[(3-gi)*32 +: 32];
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
`ifdef MIXCOL_INV_EN
    inv_next   = inv_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = BUSY;
          data_next  = in_data;
          cnt_next   = '0;
`ifdef MIXCOL_INV_EN
          inv_next   = in_inv;
`endif
        end
      end
      BUSY: begin
        data_next = data_proc;
        cnt_next  = cnt_reg + CNT_STEP;
        if (cnt_reg == GRP_MASK) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
`ifdef MIXCOL_INV_EN
      inv_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
`ifdef MIXCOL_INV_EN
      inv_reg   <= inv_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == BUSY);
  assign out_data  = data_reg;

endmodule

// File: tb/tb_mix_columns_unit.sv
// Scoreboard bench for mix_columns_unit: three instances (1, 2, 4 columns per cycle).
module tb_mix_columns_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]   in_valid, out_ready, in_ready, out_valid, busy;
  logic [127:0] in_data;
  logic         in_inv;
  logic [127:0] out_data [3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];

`ifdef MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d4d4d4d5_2d26314c;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mix_columns_unit #(.COLS_PER_CYCLE(gi == 0 ? 1 : (gi == 1 ? 2 : 4))) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
      .in_data(in_data), .in_inv(in_inv),
      .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
      .out_data(out_data[gi]), .busy(busy[gi])
    );
  end

  function automatic int cpc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  // Reference: shift-and-add GF(2^8) multiply, reduction 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
    logic [7:0]   co [4];
    logic [7:0]   a  [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) begin co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09; end
    else     begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(co[j], a[(row + j) % 4]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input int d, input string tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, out_data[d]);
    end else begin
      check(tag, out_data[d], exp_q.pop_front());
    end
  endtask

  task automatic wait_out(input int d);
    int n = 0;
    while (!out_valid[d] && n < 50) begin step(); n++; end
  endtask

  task automatic do_txn(input int d, input logic [127:0] din, input logic inv,
                        input logic [127:0] expv, input string tag);
    int n = 0;
    int acc;
    exp_q.push_back(expv);
    out_ready[d] = 1'b0;
    while (!in_ready[d] && n < 50) begin step(); n++; end
    in_data = din;
    in_inv = inv;
    in_valid[d] = 1'b1;
    step();
    acc = cyc;
    in_valid[d] = 1'b0;
    check({tag, "_busy"}, 128'(busy[d]), 128'(1));
    wait_out(d);
    check({tag, "_lat"}, 128'(cyc - acc), 128'(4 / cpc(d)));
    $display("txn dut=%0d tag=%s inv=%0d in=%h out=%h lat=%0d", d, tag, inv, din, out_data[d], cyc - acc);
    pop_check(d, tag);
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    check({tag, "_idle"}, 128'(in_ready[d]), 128'(1));
  endtask

  initial begin
    logic [127:0] s [3];
    logic [127:0] a, b, held;
    logic         pre, r_inv;
    int           acc [3];
    int           idx, got, n;

    in_valid = '0; out_ready = '0; in_data = '0; in_inv = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready",  128'(in_ready),  128'(3'b111));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    for (int d = 0; d < 3; d++) check("rst_out_data", out_data[d], 128'(0));

    for (int d = 0; d < 3; d++) do_txn(d, FWD_IN, 1'b0, FWD_OUT, "fwd_vec");

`ifdef MIXCOL_INV_EN
    // Columns 0-1 invert back to db135345 f20a225c; all columns checked against the model.
    do_txn(0, INV_IN, 1'b1, model(INV_IN, 1'b1), "inv_vec");
    do_txn(2, INV_IN, 1'b1, model(INV_IN, 1'b1), "inv_vec");
    do_txn(0, INV_IN, 1'b0, model(INV_IN, 1'b0), "inv_sel0");
`else
    do_txn(0, FWD_IN, 1'b1, FWD_OUT, "inv_off");
    do_txn(1, INV_IN, 1'b1, model(INV_IN, 1'b0), "inv_off");
`endif

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 2; k++) begin
        a = rnd128();
        r_inv = 1'($urandom_range(0, 1));
        do_txn(d, a, r_inv, model(a, r_inv & INV_EN), "rand");
      end
    end

    // Backpressure: result held for 10 cycles while a second state waits on in_valid.
    a = rnd128();
    b = rnd128();
    exp_q.push_back(model(a, 1'b0));
    exp_q.push_back(model(b, 1'b0));
    in_inv = 1'b0;
    in_data = a;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b0;
    step();
    in_data = b;
    wait_out(0);
    held = exp_q.pop_front();
    check("bp_first", out_data[0], held);
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_stable", out_data[0], held);
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
      check("bp_out_valid", 128'(out_valid[0]), 128'(1));
    end
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    check("bp_ready_after", 128'(in_ready[0]), 128'(1));
    step();
    in_valid[0] = 1'b0;
    check("bp_second_busy", 128'(busy[0]), 128'(1));
    wait_out(0);
    $display("txn dut=0 tag=bp_second in=%h out=%h", b, out_data[0]);
    pop_check(0, "bp_second");
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;

    // Reset during the second BUSY cycle discards the state.
    in_data = rnd128();
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_out_valid", 128'(out_valid[0]), 128'(0));
    check("mrst_in_ready",  128'(in_ready[0]),  128'(1));
    check("mrst_out_data",  out_data[0],        128'(0));
    a = rnd128();
    do_txn(0, a, 1'b0, model(a, 1'b0), "post_rst");

    // Back-to-back with out_ready tied high.
    for (int k = 0; k < 3; k++) begin
      s[k] = rnd128();
      exp_q.push_back(model(s[k], 1'b0));
      acc[k] = 0;
    end
    in_inv = 1'b0;
    out_ready[0] = 1'b1;
    idx = 0; got = 0; n = 0;
    in_data = s[0];
    in_valid[0] = 1'b1;
    while (got < 3 && n < 100) begin
      pre = in_valid[0] & in_ready[0];
      step();
      n++;
      if (pre) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 3) in_data = s[idx];
        else in_valid[0] = 1'b0;
      end
      if (out_valid[0]) begin
        $display("txn dut=0 tag=b2b idx=%0d out=%h", got, out_data[0]);
        pop_check(0, "b2b");
        got++;
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b_count", 128'(got), 128'(3));
    check("b2b_ii01", 128'(acc[1] - acc[0]), 128'(6));
    check("b2b_ii12", 128'(acc[2] - acc[1]), 128'(6));
    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
